// File: rtl/mxv_stream_engine_if.sv
// rtl/mxv_stream_engine_if.sv - word-in / result-out handshake bundle for the matrix-vector engine
interface mxv_stream_engine_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [ACC_W-1:0]  tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic              overrun;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, busy, done, err, overrun
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, busy, done, err, overrun
    );
endinterface

// File: rtl/mxv_stream_engine.sv
// rtl/mxv_stream_engine.sv - streaming N x N matrix times N vector engine
// Frame on rx: size N, then V[0..N-1], then the matrix row-major; results R[0..N-1] leave on tx.
module mxv_stream_engine #(
    parameter int DATA_W      = 8,
    parameter int MAX_N       = 8,
    parameter int SIGNED_MODE = 1,
    parameter int ACC_W       = 2*DATA_W + $clog2(MAX_N)
) (
    input  logic                   clk,
    input  logic                   rst,
    mxv_stream_engine_if.slave     bus
);
    localparam int CW = $clog2(MAX_N);

    typedef enum logic [1:0] {IDLE, LOAD_V, LOAD_M, SEND} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     nm1_q, nm1_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] v_q [MAX_N];
    logic [DATA_W-1:0] v_d [MAX_N];
    logic [ACC_W-1:0]  r_q [MAX_N];
    logic [ACC_W-1:0]  r_d [MAX_N];

    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  sum;
    logic              size_ok;
    logic              col_last;
    logic              row_last;

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] w);
        if (SIGNED_MODE != 0) ext = {{(ACC_W-DATA_W){w[DATA_W-1]}}, w};
        else                  ext = {{(ACC_W-DATA_W){1'b0}}, w};
    endfunction

    // Truncated ACC_W multiply yields the correct two's-complement low bits in both modes.
    assign prod     = ext(bus.rx_data) * ext(v_q[col_q]);
    assign sum      = acc_q + prod;
    assign size_ok  = (bus.rx_data != '0) && (bus.rx_data <= DATA_W'(MAX_N));
    assign col_last = (col_q == nm1_q);
    assign row_last = (row_q == nm1_q);

    always_comb begin
        state_d    = state_q;
        nm1_d      = nm1_q;
        row_d      = row_q;
        col_d      = col_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = overrun_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        v_d        = v_q;
        r_d        = r_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (size_ok) begin
                        nm1_d     = CW'(bus.rx_data - DATA_W'(1));
                        row_d     = '0;
                        col_d     = '0;
                        idx_d     = '0;
                        acc_d     = '0;
                        overrun_d = 1'b0;
                        state_d   = LOAD_V;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_V: begin
                if (bus.rx_valid) begin
                    v_d[col_q] = bus.rx_data;
                    if (col_last) begin
                        col_d   = '0;
                        state_d = LOAD_M;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            LOAD_M: begin
                if (bus.rx_valid) begin
                    if (col_last) begin
                        r_d[row_q] = sum;
                        acc_d      = '0;
                        col_d      = '0;
                        if (row_last) begin
                            // With N==1 R[0] is being written this very cycle, so forward it.
                            row_d      = '0;
                            idx_d      = '0;
                            tx_valid_d = 1'b1;
                            tx_data_d  = (row_q == '0) ? sum : r_q[0];
                            state_d    = SEND;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        acc_d = sum;
                        col_d = col_q + CW'(1);
                    end
                end
            end
            SEND: begin
                if (bus.rx_valid) overrun_d = 1'b1;
                if (tx_valid_q && bus.tx_ready) begin
                    if (idx_q == nm1_q) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        idx_d     = idx_q + CW'(1);
                        tx_data_d = r_q[idx_q + CW'(1)];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        v_q <= v_d;
        r_q <= r_d;
        if (!rst) begin
            state_q    <= IDLE;
            nm1_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nm1_q      <= nm1_d;
            row_q      <= row_d;
            col_q      <= col_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_mxv_stream_engine.sv
// tb/tb_mxv_stream_engine.sv - scoreboard bench for signed and unsigned engine instances
module tb_mxv_stream_engine;
    localparam int DATA_W = 8;
    localparam int MAX_N  = 8;
    localparam int ACC_W  = 19;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mxv_stream_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) s_if ();
    mxv_stream_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_if ();

    mxv_stream_engine #(.DATA_W(DATA_W), .MAX_N(MAX_N), .SIGNED_MODE(1), .ACC_W(ACC_W)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    mxv_stream_engine #(.DATA_W(DATA_W), .MAX_N(MAX_N), .SIGNED_MODE(0), .ACC_W(ACC_W)) u_dut_u (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] s_q [$];
    logic [ACC_W-1:0] u_q [$];
    int vv [16];
    int mm [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (s_if.tx_valid === 1'b1 && s_if.tx_ready === 1'b1) begin
            if (s_q.size() == 0) chk("s_spurious_tx_valid", 32'(s_if.tx_valid), 32'd0);
            else                 chk("s_result", 32'(s_if.tx_data), 32'(s_q.pop_front()));
        end
        if (u_if.tx_valid === 1'b1 && u_if.tx_ready === 1'b1) begin
            if (u_q.size() == 0) chk("u_spurious_tx_valid", 32'(u_if.tx_valid), 32'd0);
            else                 chk("u_result", 32'(u_if.tx_data), 32'(u_q.pop_front()));
        end
    end

    function automatic int ext8(input int w, input bit sgn);
        int x;
        x = w & 255;
        if (sgn && x > 127) x = x - 256;
        return x;
    endfunction

    task automatic send_word(input bit uns, input int w);
        if (uns) begin
            u_if.rx_data  = w[7:0];
            u_if.rx_valid = 1'b1;
        end else begin
            s_if.rx_data  = w[7:0];
            s_if.rx_valid = 1'b1;
        end
        @(posedge clk); #1;
        u_if.rx_valid = 1'b0;
        s_if.rx_valid = 1'b0;
    endtask

    task automatic run_frame(input bit uns, input int n);
        int acc;
        logic [ACC_W-1:0] e;
        for (int r = 0; r < n; r++) begin
            acc = 0;
            for (int c = 0; c < n; c++) acc += ext8(mm[r*n+c], !uns) * ext8(vv[c], !uns);
            e = acc[ACC_W-1:0];
            if (uns) u_q.push_back(e);
            else     s_q.push_back(e);
        end
        send_word(uns, n);
        for (int c = 0; c < n; c++) send_word(uns, vv[c]);
        for (int k = 0; k < n*n; k++) send_word(uns, mm[k]);
    endtask

    task automatic wait_done(input bit uns, input string tag, input bit rand_ready);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rand_ready) begin
                if (uns) u_if.tx_ready = 1'($urandom_range(0, 1));
                else     s_if.tx_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if ((uns ? u_if.done : s_if.done) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_busy_after_done"}, 32'(uns ? u_if.busy : s_if.busy), 32'd0);
        chk({tag, "_drained"}, 32'(uns ? u_q.size() : s_q.size()), 32'd0);
        s_if.tx_ready = 1'b1;
        u_if.tx_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done_pulse_end"}, 32'(uns ? u_if.done : s_if.done), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_tx_valid"}, 32'(s_if.tx_valid), 32'd0);
        chk({tag, "_s_tx_data"},  32'(s_if.tx_data),  32'd0);
        chk({tag, "_s_busy"},     32'(s_if.busy),     32'd0);
        chk({tag, "_s_done"},     32'(s_if.done),     32'd0);
        chk({tag, "_s_err"},      32'(s_if.err),      32'd0);
        chk({tag, "_s_overrun"},  32'(s_if.overrun),  32'd0);
        chk({tag, "_u_tx_valid"}, 32'(u_if.tx_valid), 32'd0);
        chk({tag, "_u_busy"},     32'(u_if.busy),     32'd0);
    endtask

    initial begin
        int seen;
        logic [ACC_W-1:0] r0;
        s_if.rx_data = '0; s_if.rx_valid = 1'b0; s_if.tx_ready = 1'b1;
        u_if.rx_data = '0; u_if.rx_valid = 1'b0; u_if.tx_ready = 1'b1;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic 2x2 frame: expected 11, 17
        vv[0] = 1; vv[1] = 2;
        mm[0] = 3; mm[1] = 4; mm[2] = 5; mm[3] = 6;
        run_frame(1'b0, 2);
        wait_done(1'b0, "basic", 1'b0);

        // Illegal sizes then N=1
        send_word(1'b0, 0);
        chk("err_n0", 32'(s_if.err), 32'd1);
        chk("err_n0_busy", 32'(s_if.busy), 32'd0);
        @(posedge clk); #1;
        chk("err_n0_pulse_end", 32'(s_if.err), 32'd0);
        send_word(1'b0, MAX_N + 1);
        chk("err_nmax1", 32'(s_if.err), 32'd1);
        chk("err_nmax1_busy", 32'(s_if.busy), 32'd0);
        vv[0] = 7; mm[0] = 3;
        run_frame(1'b0, 1);
        wait_done(1'b0, "n1", 1'b0);

        // Signed product: 0xFE * 3 = -6
        vv[0] = 8'hFE; mm[0] = 3;
        run_frame(1'b0, 1);
        wait_done(1'b0, "signed", 1'b0);

        // Unsigned worst case at N=MAX_N
        for (int i = 0; i < MAX_N; i++) vv[i] = 255;
        for (int i = 0; i < MAX_N*MAX_N; i++) mm[i] = 255;
        run_frame(1'b1, MAX_N);
        wait_done(1'b1, "unsigned_max", 1'b0);

        // Backpressure with overrun during the stall
        s_if.tx_ready = 1'b0;
        vv[0] = 1; vv[1] = 8'hFF; vv[2] = 2;
        for (int i = 0; i < 9; i++) mm[i] = i * 13 - 40;
        run_frame(1'b0, 3);
        r0 = s_q[0];
        for (int i = 0; i < 5; i++) begin
            chk("bp_tx_valid", 32'(s_if.tx_valid), 32'd1);
            chk("bp_tx_data", 32'(s_if.tx_data), 32'(r0));
            @(posedge clk); #1;
        end
        send_word(1'b0, 8'h5A);
        chk("bp_overrun", 32'(s_if.overrun), 32'd1);
        chk("bp_tx_data_after_rx", 32'(s_if.tx_data), 32'(r0));
        wait_done(1'b0, "bp", 1'b1);
        chk("overrun_sticky", 32'(s_if.overrun), 32'd1);

        // Random 4x4 frame with random backpressure; size word clears overrun
        for (int i = 0; i < 4; i++) vv[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) mm[i] = int'($urandom_range(0, 255));
        run_frame(1'b0, 4);
        chk("overrun_cleared", 32'(s_if.overrun), 32'd0);
        wait_done(1'b0, "random", 1'b1);

        // Reset in the middle of LOAD_M
        send_word(1'b0, 3);
        for (int i = 0; i < 3; i++) send_word(1'b0, i + 2);
        for (int i = 0; i < 4; i++) send_word(1'b0, i + 1);
        chk("pre_reset_busy", 32'(s_if.busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset("midreset");
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (s_if.tx_valid !== 1'b0) seen++;
        end
        chk("midreset_no_tx", 32'(seen), 32'd0);
        vv[0] = 8'h80; vv[1] = 8'h7F; vv[2] = 8'hFF;
        for (int i = 0; i < 9; i++) mm[i] = 8'h80 + i * 31;
        run_frame(1'b0, 3);
        wait_done(1'b0, "post_reset", 1'b0);

        chk("s_queue_empty", 32'(s_q.size()), 32'd0);
        chk("u_queue_empty", 32'(u_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mxv_stream_engine.md
MXV_STREAM_ENGINE -- requirements
Module: mxv_stream_engine

Interface
REQ-001 Parameter DATA_W, default 8: width of each received operand word.
REQ-002 Parameter MAX_N, default 8: maximum matrix dimension; range 2..16.
REQ-003 Parameter SIGNED_MODE, default 1: 1 = two's-complement operands, 0 = unsigned operands.
REQ-004 Parameter ACC_W, default 2*DATA_W+$clog2(MAX_N): result and accumulator width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 rx_data  in  DATA_W  received word.
REQ-008 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-009 tx_data  out  ACC_W  result word.
REQ-010 tx_valid  out  1  tx_data is valid; held until accepted.
REQ-011 tx_ready  in  1  downstream accepts when tx_valid and tx_ready are both high.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle pulse after the last result is accepted.
REQ-014 err  out  1  one-cycle pulse when an illegal size word is received.
REQ-015 overrun  out  1  sticky flag: a word arrived while in SEND.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD_V, LOAD_M, SEND.
REQ-017 In IDLE, an rx_valid word N with 1<=N<=MAX_N SHALL latch N, clear overrun, zero the row/column counters and the accumulator, and move to LOAD_V.
REQ-018 In IDLE, an rx_valid word with N==0 or N>MAX_N SHALL pulse err for one cycle and keep the FSM in IDLE.
REQ-019 In LOAD_V, N rx_valid words SHALL be stored in order as V[0..N-1]; the N-th word SHALL move the FSM to LOAD_M.
REQ-020 In LOAD_M, N*N words SHALL be accepted row-major; each word m at (row r, col c) SHALL update acc <= acc + m*V[c] in the cycle it arrives.
REQ-021 Operands SHALL be sign-extended when SIGNED_MODE=1 and zero-extended when SIGNED_MODE=0; products and sums are ACC_W wide with no saturation.
REQ-022 At c==N-1, R[r] SHALL be written with acc+m*V[c] and acc SHALL clear in the same cycle; c wraps to 0 and r increments.
REQ-023 The cycle after the last matrix word (r==N-1, c==N-1) is accepted, the FSM SHALL enter SEND with tx_valid=1 and tx_data=R[0].
REQ-024 In SEND, each tx_valid&&tx_ready cycle SHALL advance the output index; tx_data and tx_valid SHALL remain stable while tx_ready is low.
REQ-025 Acceptance of R[N-1] SHALL drop tx_valid, pulse done for one cycle in the following cycle, and return the FSM to IDLE.
REQ-026 rx_valid in SEND SHALL drop the word and set overrun.
REQ-027 rx_valid cycles without a strobe SHALL change no state; gaps of any length between words are legal.
REQ-028 Results SHALL leave in row order R[0]..R[N-1], exactly N per frame.

Reset
REQ-029 While rst==0 at a clock edge, the FSM SHALL go to IDLE.
REQ-030 While rst==0 at a clock edge, tx_valid, tx_data, busy, done, err, overrun, all counters and acc SHALL be 0.
REQ-031 V and R contents need not be reset; they SHALL never be observable before being written in the current frame.
REQ-032 Reset mid-frame SHALL abandon the frame with no partial output; the next frame SHALL compute correctly.

Verification
REQ-033 Basic frame: DATA_W=8, SIGNED_MODE=1, words 2,1,2,3,4,5,6 with tx_ready=1 -> tx 11 then 17, then done pulse, busy=0.
REQ-034 Size errors: N=0 -> err pulse, FSM stays in IDLE. N=MAX_N+1 -> err pulse, FSM stays in IDLE. Then 1,7,3 -> tx 21.
REQ-035 Signed result: SIGNED_MODE=1, ACC_W=19, words 1,0xFE,0x03 -> tx_data 0x7FFFA (-6).
REQ-036 Unsigned worst case: SIGNED_MODE=0, MAX_N=8, N=8, all operands 0xFF -> eight results of 520200 each, no overflow.
REQ-037 Backpressure: tx_ready low for 5 cycles in SEND -> tx_valid stays high and tx_data stays at R[0]. While stalled, rx_valid -> overrun=1. Then tx_ready=1 -> remaining results follow in order.
REQ-038 Reset during LOAD_M: outputs go to reset values the next cycle, no tx_valid appears, and a following full frame gives correct results.
